// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt requester: latches rising edges into a pending register,
// issues a one-cycle intr trap at a pipeline-safe point and a one-cycle intr_end on mret.
module irq_ctrl #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] src_en,
    input  logic             csr_meie,
    input  logic             csr_mie,
    input  logic             pipe_ready,
    input  logic             mret_ex,
    output logic             intr,
    output logic             intr_end,
    output logic [ID_W-1:0]  intr_id,
    output logic [N_SRC-1:0] irq_pend,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ISR  = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [N_SRC-1:0] irq_prev;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] claim_mask;
    logic [ID_W-1:0]  winner;
    logic             any_elig;
    logic             en_ok;
    logic             claim;

    assign rise     = irq_src & ~irq_prev;
    assign eligible = irq_pend & src_en;
    assign any_elig = |eligible;
    assign en_ok    = csr_meie & csr_mie & any_elig;

    // Scan from the top down so the lowest set index is the one left standing.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    // Trap handshake: in ARM the request is implicitly valid while en_ok holds;
    // the CPU accepts it in any cycle with pipe_ready=1, and that cycle is the claim.
    always_comb begin
        state_nx = state;
        claim    = 1'b0;
        case (state)
            IDLE: if (en_ok) state_nx = ARM;
            ARM: begin
                if (!en_ok) begin
                    state_nx = IDLE;
                end else if (pipe_ready) begin
                    claim    = 1'b1;
                    state_nx = ISR;
                end
            end
            ISR:     if (mret_ex) state_nx = RET;
            RET:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign claim_mask = claim ? (N_SRC'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            irq_prev <= '0;
            irq_pend <= '0;
            intr     <= 1'b0;
            intr_end <= 1'b0;
            intr_id  <= '0;
        end else begin
            state    <= state_nx;
            irq_prev <= irq_src;
            // A fresh edge in the claim cycle survives the clear.
            irq_pend <= (irq_pend & ~claim_mask) | rise;
            intr     <= claim;
            intr_end <= (state == ISR) && mret_ex;
            if (claim) intr_id <= winner;
        end
    end

    assign busy      = (state == ISR) || (state == RET);
    assign dbg_state = state;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with explicit expectations, then random
// stimulus, every cycle compared against a rule-level reference model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_src;
    logic [3:0] src_en;
    logic       csr_meie;
    logic       csr_mie;
    logic       pipe_ready;
    logic       mret_ex;
    logic       intr;
    logic       intr_end;
    logic [1:0] intr_id;
    logic [3:0] irq_pend;
    logic       busy;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_SRC(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_src   (irq_src),
        .src_en    (src_en),
        .csr_meie  (csr_meie),
        .csr_mie   (csr_mie),
        .pipe_ready(pipe_ready),
        .mret_ex   (mret_ex),
        .intr      (intr),
        .intr_end  (intr_end),
        .intr_id   (intr_id),
        .irq_pend  (irq_pend),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=idle 1=armed 2=in handler 3=returning.
    int         m_phase = 0;
    logic [3:0] m_prev  = '0;
    logic [3:0] m_pend  = '0;
    logic [1:0] m_id    = '0;
    logic       m_intr  = 1'b0;
    logic       m_end   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] s, input logic [3:0] e,
                              input logic meie, input logic mie, input logic pr,
                              input logic mret);
        logic [3:0] edges;
        logic [3:0] elig;
        logic [3:0] kept;
        int         win;
        bit         ok;
        if (r) begin
            m_phase = 0; m_prev = '0; m_pend = '0; m_id = '0; m_intr = 0; m_end = 0;
            return;
        end
        edges = s & ~m_prev;
        elig  = m_pend & e;
        win   = -1;
        for (int i = 0; i < 4; i++) if (elig[i] && win < 0) win = i;
        ok     = meie && mie && (win >= 0);
        m_intr = 0;
        m_end  = 0;
        kept   = m_pend;
        case (m_phase)
            0: if (ok) m_phase = 1;
            1: begin
                if (!ok) m_phase = 0;
                else if (pr) begin
                    m_phase   = 2;
                    m_intr    = 1;
                    m_id      = 2'(win);
                    kept[win] = 1'b0;
                end
            end
            2: if (mret) begin m_phase = 3; m_end = 1; end
            default: m_phase = 0;
        endcase
        m_pend = kept | edges;
        m_prev = s;
    endtask

    task automatic tick();
        logic       r    = rst;
        logic [3:0] s    = irq_src;
        logic [3:0] e    = src_en;
        logic       meie = csr_meie;
        logic       mie  = csr_mie;
        logic       pr   = pipe_ready;
        logic       mr   = mret_ex;
        @(posedge clk);
        #1;
        model_step(r, s, e, meie, mie, pr, mr);
        chk("model_intr", 32'(intr), 32'(m_intr));
        chk("model_intr_end", 32'(intr_end), 32'(m_end));
        chk("model_intr_id", 32'(intr_id), 32'(m_id));
        chk("model_irq_pend", 32'(irq_pend), 32'(m_pend));
        chk("model_busy", 32'(busy), 32'(m_phase >= 2));
        chk("pulse_overlap", 32'(intr & intr_end), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mret_pulse();
        mret_ex = 1'b1;
        tick();
        mret_ex = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; src_en = 4'hF; csr_meie = 1'b1; csr_mie = 1'b1;
        pipe_ready = 1'b1; mret_ex = 1'b0;
        ticks(2);
        chk("rst_intr", 32'(intr), 32'd0);
        chk("rst_intr_end", 32'(intr_end), 32'd0);
        chk("rst_intr_id", 32'(intr_id), 32'd0);
        chk("rst_irq_pend", 32'(irq_pend), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        ticks(3);

        // Single source, best-case latency.
        irq_src = 4'b0100;
        tick();
        chk("single_pend", 32'(irq_pend), 32'h4);
        tick();
        chk("single_arm_no_intr", 32'(intr), 32'd0);
        tick();
        chk("single_intr", 32'(intr), 32'd1);
        chk("single_id", 32'(intr_id), 32'd2);
        chk("single_pend_clr", 32'(irq_pend), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_intr_once", 32'(intr), 32'd0);
        ticks(5);
        mret_pulse();
        chk("single_end", 32'(intr_end), 32'd1);
        chk("single_end_busy", 32'(busy), 32'd1);
        chk("single_end_id", 32'(intr_id), 32'd2);
        tick();
        chk("single_end_once", 32'(intr_end), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        irq_src = '0;
        ticks(2);

        // Priority and back-to-back spacing.
        irq_src = 4'b1010;
        ticks(3);
        chk("prio_intr", 32'(intr), 32'd1);
        chk("prio_id", 32'(intr_id), 32'd1);
        chk("prio_pend_left", 32'(irq_pend), 32'h8);
        ticks(2);
        mret_pulse();
        chk("prio_end", 32'(intr_end), 32'd1);
        ticks(2);
        chk("prio_gap_no_intr", 32'(intr), 32'd0);
        tick();
        chk("prio_second_intr", 32'(intr), 32'd1);
        chk("prio_second_id", 32'(intr_id), 32'd3);
        mret_pulse();
        irq_src = '0;
        ticks(2);

        // Global enable gating, then pipe_ready gating.
        csr_mie = 1'b0;
        irq_src = 4'b0100;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("gate_mie_no_intr", 32'(intr), 32'd0);
        end
        chk("gate_pend_held", 32'(irq_pend), 32'h4);
        pipe_ready = 1'b0;
        csr_mie    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate_pr_no_intr", 32'(intr), 32'd0);
        end
        pipe_ready = 1'b1;
        tick();
        chk("gate_pr_intr", 32'(intr), 32'd1);
        chk("gate_pr_id", 32'(intr_id), 32'd2);
        mret_pulse();
        irq_src = '0;
        ticks(2);

        // Masked source stays pending and is never serviced.
        src_en  = 4'b1101;
        irq_src = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_no_intr", 32'(intr), 32'd0);
        end
        chk("mask_pend", 32'(irq_pend), 32'h2);
        src_en = 4'hF;
        ticks(3);
        chk("unmask_id", 32'(intr_id), 32'd1);
        mret_pulse();
        irq_src = '0;
        ticks(2);

        // Higher-priority edge preempts while armed.
        pipe_ready = 1'b0;
        irq_src    = 4'b1000;
        ticks(2);
        irq_src = 4'b1001;
        tick();
        chk("preempt_pend", 32'(irq_pend), 32'h9);
        pipe_ready = 1'b1;
        tick();
        chk("preempt_intr", 32'(intr), 32'd1);
        chk("preempt_id", 32'(intr_id), 32'd0);
        chk("preempt_pend3", 32'(irq_pend), 32'h8);
        mret_pulse();
        ticks(3);
        chk("preempt_next_id", 32'(intr_id), 32'd3);
        mret_pulse();
        irq_src = '0;
        ticks(2);

        // Spurious mret in IDLE.
        mret_pulse();
        chk("spurious_no_end", 32'(intr_end), 32'd0);
        tick();

        // Re-trigger in the claim cycle keeps the pending bit.
        irq_src = 4'b0100;
        tick();
        irq_src = 4'b0000;
        tick();
        irq_src = 4'b0100;
        tick();
        chk("retrig_intr", 32'(intr), 32'd1);
        chk("retrig_pend", 32'(irq_pend), 32'h4);

        // Reset inside the handler.
        irq_src = '0;
        rst     = 1'b1;
        tick();
        chk("rst_isr_busy", 32'(busy), 32'd0);
        chk("rst_isr_pend", 32'(irq_pend), 32'd0);
        chk("rst_isr_id", 32'(intr_id), 32'd0);
        rst = 1'b0;
        mret_pulse();
        chk("rst_isr_no_end", 32'(intr_end), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom_range(0, 15));
            src_en     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            csr_mie    = ($urandom_range(0, 7) != 0);
            csr_meie   = ($urandom_range(0, 7) != 0);
            pipe_ready = 1'($urandom_range(0, 1));
            mret_ex    = ($urandom_range(0, 5) == 0);
            rst        = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
